// File: rtl/ahb_cfg_master.sv
// ahb_cfg_master: bus initiator that loads four image-engine configuration
// words into the slave register bank, then polls the slave status word
// until the engine reports completion.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; outputs held, busy low
// S_ADDR | single address-phase cycle, hwrite high for word[idx]
// S_DATA | data phase, waiting for hready or the ready timeout
// S_POLL | config complete; waiting for all-ones then zero on hrdata
module ahb_cfg_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RDY_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic [31:0] cfg_raddr,
    input  logic [31:0] cfg_waddr,
    input  logic [31:0] cfg_boundary,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [31:0] hrdata,
    output logic        busy,
    output logic        cfg_done,
    output logic        job_done,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_POLL} state_t;

    localparam int            TW         = $clog2(RDY_TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LIMIT = TW'(RDY_TIMEOUT);

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            armed_q, armed_d;
    logic [15:0]     sh_width_q, sh_width_d;
    logic [15:0]     sh_height_q, sh_height_d;
    logic [31:0]     sh_raddr_q, sh_raddr_d;
    logic [31:0]     sh_waddr_q, sh_waddr_d;
    logic [31:0]     sh_bound_q, sh_bound_d;
    logic [31:0]     haddr_q, haddr_d;
    logic [31:0]     hwdata_q, hwdata_d;
    logic            hwrite_q, hwrite_d;
    logic            busy_q, busy_d;
    logic            cfg_done_q, cfg_done_d;
    logic            job_done_q, job_done_d;
    logic            err_q, err_d;
    logic [31:0]     word_d;

    // State register: every flop, synchronous reset to the idle/all-zero state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            tcnt_q      <= '0;
            armed_q     <= 1'b0;
            sh_width_q  <= '0;
            sh_height_q <= '0;
            sh_raddr_q  <= '0;
            sh_waddr_q  <= '0;
            sh_bound_q  <= '0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            hwrite_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            job_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tcnt_q      <= tcnt_d;
            armed_q     <= armed_d;
            sh_width_q  <= sh_width_d;
            sh_height_q <= sh_height_d;
            sh_raddr_q  <= sh_raddr_d;
            sh_waddr_q  <= sh_waddr_d;
            sh_bound_q  <= sh_bound_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            hwrite_q    <= hwrite_d;
            busy_q      <= busy_d;
            cfg_done_q  <= cfg_done_d;
            job_done_q  <= job_done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: sequencing, word index, ready timer, armed flag, shadow capture
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        armed_d     = armed_q;
        sh_width_d  = sh_width_q;
        sh_height_d = sh_height_q;
        sh_raddr_d  = sh_raddr_q;
        sh_waddr_d  = sh_waddr_q;
        sh_bound_d  = sh_bound_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_width_d  = cfg_width;
                    sh_height_d = cfg_height;
                    sh_raddr_d  = cfg_raddr;
                    sh_waddr_d  = cfg_waddr;
                    sh_bound_d  = cfg_boundary;
                    idx_d       = 2'd0;
                    armed_d     = 1'b0;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                tcnt_d  = TW'(1);
                state_d = S_DATA;
            end
            S_DATA: begin
                // hready takes priority over the timeout on the same cycle
                if (hready) begin
                    if (idx_q == 2'd3) begin
                        armed_d = 1'b0;
                        state_d = S_POLL;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_ADDR;
                    end
                end else if (tcnt_q == TCNT_LIMIT) begin
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_POLL: begin
                // a zero status only counts once the engine has been seen running,
                // otherwise the pre-run idle value would look like completion
                if (armed_q && hrdata == 32'h0000_0000) begin
                    state_d = S_IDLE;
                end else if (hrdata == 32'hFFFF_FFFF) begin
                    armed_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word selection from the shadows that will be valid after this edge
    always_comb begin
        word_d = 32'h0000_0000;
        unique case (idx_d)
            2'd0: word_d = {sh_width_d, sh_height_d};
            2'd1: word_d = sh_raddr_d;
            2'd2: word_d = sh_waddr_d;
            2'd3: word_d = sh_bound_d;
            default: word_d = 32'h0000_0000;
        endcase
    end

    // Output logic: registered bus and status outputs derived from the transition
    always_comb begin
        haddr_d    = haddr_q;
        hwdata_d   = hwdata_q;
        hwrite_d   = 1'b0;
        cfg_done_d = 1'b0;
        job_done_d = 1'b0;
        err_d      = err_q;
        busy_d     = (state_d != S_IDLE);
        if (state_d == S_ADDR) begin
            hwrite_d = 1'b1;
            haddr_d  = BASE_ADDR | {30'd0, idx_d};
            hwdata_d = word_d;
        end
        if (state_q == S_IDLE && start) begin
            err_d = 1'b0;
        end
        if (state_q == S_DATA && !hready && tcnt_q == TCNT_LIMIT) begin
            err_d = 1'b1;
        end
        if (state_q == S_DATA && hready && idx_q == 2'd3) begin
            cfg_done_d = 1'b1;
            haddr_d    = BASE_ADDR;
        end
        if (state_q == S_POLL && state_d == S_IDLE) begin
            job_done_d = 1'b1;
        end
    end

    assign haddr    = haddr_q;
    assign hwrite   = hwrite_q;
    assign hwdata   = hwdata_q;
    assign busy     = busy_q;
    assign cfg_done = cfg_done_q;
    assign job_done = job_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ahb_cfg_master.sv
// Bench for ahb_cfg_master: table of configuration vectors run through full
// config+poll sequences, a write scoreboard, and hand-written corner cases
// (stale status, ready timeout, mid-transfer reset, start while busy).
module tb_ahb_cfg_master;

    localparam logic [31:0] BASE = 32'h4000_0010;
    localparam int          TO   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_width = '0;
    logic [15:0] cfg_height = '0;
    logic [31:0] cfg_raddr = '0;
    logic [31:0] cfg_waddr = '0;
    logic [31:0] cfg_boundary = '0;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready = 1'b0;
    logic [31:0] hrdata = '0;
    logic        busy;
    logic        cfg_done;
    logic        job_done;
    logic        err;

    ahb_cfg_master #(.BASE_ADDR(BASE), .RDY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_raddr(cfg_raddr), .cfg_waddr(cfg_waddr), .cfg_boundary(cfg_boundary),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata),
        .busy(busy), .cfg_done(cfg_done), .job_done(job_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] bd;
        logic [31:0] exp_w0;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t vt[4];
    wr_t  exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: acknowledges a write two cycles after the address phase,
    // optionally refusing one register index to provoke a timeout.
    logic       stg1 = 1'b0;
    logic       stg2 = 1'b0;
    logic       blk_en = 1'b0;
    logic [1:0] blk_idx = 2'd0;
    always @(negedge clk) begin
        hready = stg2;
        stg2   = stg1;
        stg1   = hwrite && !(blk_en && haddr[1:0] == blk_idx);
    end

    // Scoreboard: every address-phase write is popped against the queue
    logic prev_hw = 1'b0;
    always @(negedge clk) begin
        wr_t e;
        if (!rst && hwrite) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_write: got addr %0h data %0h with nothing expected", haddr, hwdata);
            end else begin
                e = exp_q.pop_front();
                check("sb_haddr", haddr, e.addr);
                check("sb_hwdata", hwdata, e.data);
            end
            check("hwrite_back_to_back", 32'(prev_hw), 32'd0);
        end
        prev_hw = hwrite;
    end

    task automatic drive_cfg(input vec_t v);
        cfg_width    = v.w;
        cfg_height   = v.h;
        cfg_raddr    = v.ra;
        cfg_waddr    = v.wa;
        cfg_boundary = v.bd;
    endtask

    task automatic push_words(input vec_t v, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = BASE | 32'(i);
            case (i)
                0: e.data = v.exp_w0;
                1: e.data = v.ra;
                2: e.data = v.wa;
                default: e.data = v.bd;
            endcase
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_alt_cfg();
        cfg_width    = 16'h1234;
        cfg_height   = 16'h5678;
        cfg_raddr    = 32'hDEAD_0000;
        cfg_waddr    = 32'hBEEF_0000;
        cfg_boundary = 32'h0BAD_0BAD;
    endtask

    // Full four-word configuration; returns at the negedge of the cfg_done cycle
    task automatic run_cfg(input int vi, input bit intrude);
        int wr_at[4] = '{-1, -1, -1, -1};
        int n_wr = 0;
        int done_at = -1;
        bit busy_ok = 1'b1;
        @(negedge clk);
        drive_cfg(vt[vi]);
        start = 1'b1;
        push_words(vt[vi], 4);
        @(negedge clk);
        start = 1'b0;
        check("err_clear_on_start", 32'(err), 32'd0);
        for (int k = 0; k < 24; k++) begin
            if (hwrite && n_wr < 4) begin
                wr_at[n_wr] = k;
                n_wr++;
            end
            if (!busy) busy_ok = 1'b0;
            if (cfg_done) begin
                done_at = k;
                break;
            end
            if (intrude && k == 1) begin
                drive_alt_cfg();
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("cfg_write_count", 32'(n_wr), 32'd4);
        for (int i = 0; i < 4; i++) check("cfg_write_cycle", 32'(wr_at[i]), 32'(3 * i));
        check("cfg_done_cycle", 32'(done_at), 32'd12);
        check("busy_during_cfg", 32'(busy_ok), 32'd1);
    endtask

    // Status poll: all-ones for 'hold' cycles then zero
    task automatic run_poll(input int hold);
        int pre = 0;
        int cnt = 0;
        int first = -1;
        hrdata = 32'hFFFF_FFFF;
        repeat (hold) begin
            @(negedge clk);
            if (job_done) pre++;
        end
        hrdata = 32'h0000_0000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (job_done) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check("job_done_early", 32'(pre), 32'd0);
        check("job_done_count", 32'(cnt), 32'd1);
        check("job_done_latency", 32'(first), 32'd1);
        check("busy_after_job", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_haddr"}, haddr, 32'd0);
        check({tag, "_hwdata"}, hwdata, 32'd0);
        check({tag, "_ctl"}, {27'd0, hwrite, busy, cfg_done, job_done, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_idx1;
        int t_err;
        int cnt;
        bit found;
        bit ok;

        vt[0] = '{16'd640, 16'd480, 32'h0000_1000, 32'h0000_8000, 32'h0000_00FF, 32'h0280_01E0};
        vt[1] = '{16'd1920, 16'd1080, 32'hA000_0000, 32'hB000_0040, 32'h0000_0004, 32'h0780_0438};
        vt[2] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_0001};
        vt[3] = '{16'h0000, 16'h0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};

        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // start together with rst: rst wins
        drive_cfg(vt[0]);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_beats_start_busy", 32'(busy), 32'd0);
        check("rst_beats_start_hwrite", 32'(hwrite), 32'd0);
        @(negedge clk);
        check("rst_beats_start_idle", 32'(busy), 32'd0);

        // table-driven nominal sequences
        for (int i = 0; i < 4; i++) begin
            run_cfg(i, 1'b0);
            check("poll_haddr", haddr, BASE);
            run_poll(i == 0 ? 20 : i);
        end

        // stale zero status never completes the job
        run_cfg(2, 1'b0);
        hrdata = 32'h0000_0000;
        cnt = 0;
        ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (job_done) cnt++;
            if (!busy) ok = 1'b0;
        end
        check("stale_job_done", 32'(cnt), 32'd0);
        check("stale_busy", 32'(ok), 32'd1);
        run_poll(3);

        // ready timeout on the idx 1 write
        blk_en = 1'b1;
        blk_idx = 2'd1;
        @(negedge clk);
        drive_cfg(vt[1]);
        start = 1'b1;
        push_words(vt[1], 2);
        @(negedge clk);
        start = 1'b0;
        t_idx1 = -1;
        t_err = -1;
        for (int k = 0; k < 24; k++) begin
            if (hwrite && haddr[1:0] == 2'd1 && t_idx1 < 0) t_idx1 = k;
            if (err) begin
                t_err = k;
                break;
            end
            @(negedge clk);
        end
        check("to_idx1_addr_cycle", 32'(t_idx1), 32'd3);
        check("to_err_cycle", 32'(t_err), 32'(3 + TO + 1));
        check("to_busy", 32'(busy), 32'd0);
        check("to_hwrite", 32'(hwrite), 32'd0);
        blk_en = 1'b0;
        repeat (3) @(negedge clk);
        check("to_err_sticky", 32'(err), 32'd1);
        run_cfg(0, 1'b0);
        run_poll(2);

        // reset during the idx 2 data phase
        @(negedge clk);
        drive_cfg(vt[3]);
        start = 1'b1;
        push_words(vt[3], 4);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (hwrite && haddr[1:0] == 2'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_idx2_reached", 32'(found), 32'd1);
        @(negedge clk);
        check("rst_in_data_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("after_mid_reset");
        repeat (3) @(negedge clk);
        run_cfg(1, 1'b0);
        run_poll(5);

        // start while busy: during DATA (inside run_cfg) and during POLL
        run_cfg(1, 1'b1);
        drive_alt_cfg();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (hwrite || !busy) ok = 1'b0;
            @(negedge clk);
        end
        check("poll_start_ignored", 32'(ok), 32'd1);
        run_poll(4);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
